// File: rtl/fixed_point_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_point_pkg
//  Brief    : Shared constants and types for the fixed-point basic-op library
//             (saturation limits, divider state encoding, iteration count).
//  Revision : 1.0  initial release
// ============================================================================
package fixed_point_pkg;

  localparam logic [15:0] MAX_16 = 16'h7FFF;
  localparam logic [15:0] MIN_16 = 16'h8000;
  localparam logic [31:0] MAX_32 = 32'h7FFF_FFFF;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_ITERS = DIV_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_s_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_s_step
//  Brief    : One restoring shift/subtract division step (combinational).
//             Shifts the partial remainder left, subtracts the divisor when it
//             fits, and shifts the resulting quotient bit into q.
//  Revision : 1.0  initial release
// ============================================================================
module div_s_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   i_num,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH:0]   i_den,
  output logic [WIDTH:0]   o_num,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_shift;
  logic           w_ge;

  // Remainder stays below den (< 2^(WIDTH-1)), so the shift never overflows WIDTH+1 bits
  always_comb begin
    w_shift = i_num << 1;
    w_ge    = (w_shift >= i_den);
    o_num   = w_ge ? (w_shift - i_den) : w_shift;
    o_q     = (i_q << 1) | {{(WIDTH-1){1'b0}}, w_ge};
  end

endmodule
`default_nettype wire

// File: rtl/div_s_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_s_seq
//  Brief    : Sequential Q15 fractional divide, quot = var1/var2 for
//             0 <= var1 <= var2, var2 > 0. One quotient bit per clock,
//             valid/ready handshake on input and output.
//  Config   : DIV_S_ERR_EN - when defined, illegal operands return err=1 and
//             quot=0; otherwise err is tied low and illegal operands saturate.
//  Revision : 1.0  initial release
// ============================================================================
module div_s_seq
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] var1,
  input  logic [WIDTH-1:0] var2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic             err
);

  localparam int               ITERS = WIDTH - 1;
  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  div_state_t       state_q, state_d;
  logic [WIDTH:0]   num_q, num_d;
  logic [WIDTH:0]   den_q, den_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;

  logic             w_accept;
  logic             w_var1_neg;
  logic             w_var2_nonpos;
  logic             w_illegal;
  logic [WIDTH:0]   w_step_num;
  logic [WIDTH-1:0] w_step_q;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quot      = quot_q;
  assign w_accept  = in_valid & in_ready;

  // Operand legality is judged on the live inputs at the accepting edge
  always_comb begin
    w_var1_neg    = var1[WIDTH-1];
    w_var2_nonpos = var2[WIDTH-1] | (var2 == '0);
    w_illegal     = w_var2_nonpos | w_var1_neg | ($signed(var1) > $signed(var2));
  end

  div_s_step #(.WIDTH(WIDTH)) u_step (
    .i_num (num_q),
    .i_q   (q_q),
    .i_den (den_q),
    .o_num (w_step_num),
    .o_q   (w_step_q)
  );

  // Next-state and datapath: fast paths go straight to DONE, others iterate in CALC
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          num_d = {1'b0, var1};
          den_d = {1'b0, var2};
          q_d   = '0;
          cnt_d = '0;
          if (w_illegal) begin
            state_d = DONE;
`ifdef DIV_S_ERR_EN
            quot_d  = '0;
`else
            // Only var1 > var2 with both positive saturates high
            quot_d  = (w_var2_nonpos | w_var1_neg) ? '0 : Q_MAX;
`endif
          end else if (var1 == '0) begin
            state_d = DONE;
            quot_d  = '0;
          end else if (var1 == var2) begin
            state_d = DONE;
            quot_d  = Q_MAX;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        num_d = w_step_num;
        q_d   = w_step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = DONE;
          quot_d  = w_step_q;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      den_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
    end
  end

`ifdef DIV_S_ERR_EN
  logic err_q, err_d;

  // Error flag is refreshed on every accept and held until the next one
  always_comb begin
    err_d = err_q;
    if (w_accept) err_d = w_illegal;
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic w_accept_unused;
  assign w_accept_unused = w_accept;
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_s_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_s_seq
//  Brief    : Self-checking bench for div_s_seq. Expected results come from an
//             independent integer model and travel through a scoreboard queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_s_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] var1;
  logic [W-1:0] var2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quot;
  logic         err;

  always #5 clk = ~clk;

  div_s_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .var1      (var1),
    .var2      (var2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .err       (err)
  );

  typedef struct {
    logic [15:0] q;
    logic        e;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: exact integer division of var1*2^15 by var2, plus the fast paths
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    int   sa;
    int   sbv;
    bit   ill;
    sa    = $signed(a);
    sbv   = $signed(b);
    ill   = (sbv <= 0) || (sa < 0) || (sa > sbv);
    r.e   = 1'b0;
    r.lat = 1;
    r.q   = 16'h0000;
    if (ill) begin
`ifdef DIV_S_ERR_EN
      r.e = 1'b1;
      r.q = 16'h0000;
`else
      r.q = (sbv > 0 && sa >= 0) ? 16'h7FFF : 16'h0000;
`endif
    end else if (sa == 0) begin
      r.q = 16'h0000;
    end else if (sa == sbv) begin
      r.q = 16'h7FFF;
    end else begin
      r.q   = 16'((sa * 32768) / sbv);
      r.lat = 16;
    end
    return r;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold, input bit noise);
    exp_t e;
    int   lat;
    @(negedge clk);
    var1     = a;
    var2     = b;
    in_valid = 1'b1;
    lat = 0;
    while (!in_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    if (noise) begin
      var1 = 16'($urandom);
      var2 = 16'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    @(negedge clk);
    lat = 1;
    check("in_ready_busy", 32'(in_ready), 32'd0);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check("out_valid", 32'(out_valid), 32'd1);
    check("latency", 32'(lat), 32'(e.lat));
    check("quot", 32'(quot), 32'(e.q));
    check("err", 32'(err), 32'(e.e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_quot", 32'(quot), 32'(e.q));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    bit          seen;
    logic [15:0] ra;
    logic [15:0] rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    var1      = '0;
    var2      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quot", 32'(quot), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    run_op(16'h2000, 16'h4000, 0, 1'b0);
    run_op(16'h0001, 16'h0003, 0, 1'b0);
    run_op(16'h4000, 16'h7FFF, 0, 1'b1);
    run_op(16'h1234, 16'h1234, 0, 1'b0);
    run_op(16'h0000, 16'h0100, 0, 1'b0);
    run_op(16'h5000, 16'h4000, 0, 1'b0);
    run_op(16'h1000, 16'h0000, 0, 1'b0);
    run_op(16'hF000, 16'h4000, 0, 1'b0);
    run_op(16'h0100, 16'hC000, 0, 1'b0);
    run_op(16'h3000, 16'h6001, 5, 1'b0);
    run_op(16'h1234, 16'h1234, 3, 1'b1);
    run_op(16'h7FFE, 16'h7FFF, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      rb = 16'($urandom_range(2, 32767));
      ra = 16'($urandom_range(1, int'(rb) - 1));
      run_op(ra, rb, 0, 1'b0);
    end

    // Reset in the middle of CALC discards the pending result
    @(negedge clk);
    var1     = 16'h2000;
    var2     = 16'h4000;
    in_valid = 1'b1;
    sb.push_back(model(16'h2000, 16'h4000));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("rst_mid_no_valid", 32'(seen), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    run_op(16'h2000, 16'h4000, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
